// File: rtl/input_port_pkg.sv
// input_port_pkg: shared defaults, rd_data field offsets and the
// debounce counter width helper for the input capture port.
package input_port_pkg;

  localparam int NUM_BTN_DEF  = 4;
  localparam int SW_W_DEF     = 16;
  localparam int DEBOUNCE_DEF = 1000000;

  // rd_data layout for the default sizing: {pad, event, level, switches}
  localparam int SW_LSB  = 0;
  localparam int LVL_LSB = SW_W_DEF;
  localparam int EVT_LSB = SW_W_DEF + NUM_BTN_DEF;

  // Smallest counter width that can hold DEBOUNCE_CYCLES-1.
  function automatic int cnt_w_for(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int CNT_W_DEF = cnt_w_for(DEBOUNCE_DEF);

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchronizer, stability counter and
// accepted-level flop for one input pin; rise_o marks a 0->1 accept.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count mismatching cycles; accept the new level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_o   = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = s2_q;
        rise_o   = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer chain, counter and accepted level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/input_capture_port.sv
// input_capture_port: pushbutton/switch capture with sticky press events.
// Build option: define SW_DEBOUNCE_EN to debounce the switches as well.
module input_capture_port
  import input_port_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int SW_W            = SW_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic               clk_100mhz,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [SW_W-1:0]    sw_raw,
  input  logic               event_ack,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [SW_W-1:0]    sw_value,
  output logic [NUM_BTN-1:0] btn_event,
  output logic               event_valid,
  output logic [31:0]        rd_data
);

  localparam int LVL_OFS = SW_LSB + SW_W;
  localparam int EVT_OFS = LVL_OFS + NUM_BTN;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_dc
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (EVT_OFS + NUM_BTN > 32) begin : g_bad_width
    $error("rd_data fields exceed 32 bits");
  end

  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_event_q;
  logic [NUM_BTN-1:0] btn_event_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn (
      .clk_i   (clk_100mhz),
      .rst_i   (reset),
      .raw_i   (btn_raw[g]),
      .stable_o(btn_level[g]),
      .rise_o  (btn_rise[g])
    );
  end

`ifdef SW_DEBOUNCE_EN
  for (genvar g = 0; g < SW_W; g++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_sw (
      .clk_i   (clk_100mhz),
      .rst_i   (reset),
      .raw_i   (sw_raw[g]),
      .stable_o(sw_value[g]),
      .rise_o  ()
    );
  end
`else
  logic [SW_W-1:0] sw_s1_q;
  logic [SW_W-1:0] sw_s2_q;

  // Plain two-flop synchronizer for the switch bank.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_raw;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign sw_value = sw_s2_q;
`endif

  // An ack clears every bit pending at that edge; a press
  // accepted on the same edge still lands.
  always_comb begin
    btn_event_d = btn_event_q | btn_rise;
    if (event_ack) begin
      btn_event_d = btn_rise;
    end
  end

  // Sticky press flags.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      btn_event_q <= '0;
    end else begin
      btn_event_q <= btn_event_d;
    end
  end

  assign btn_event   = btn_event_q;
  assign event_valid = |btn_event_q;

  // Status word assembled from flop outputs only.
  always_comb begin
    rd_data = '0;
    rd_data[SW_LSB +: SW_W]     = sw_value;
    rd_data[LVL_OFS +: NUM_BTN] = btn_level;
    rd_data[EVT_OFS +: NUM_BTN] = btn_event_q;
  end

endmodule

// File: tb/tb_input_capture_port.sv
// tb_input_capture_port: directed table, hand sequences and random
// stimulus checked against a history-based reference model.
module tb_input_capture_port;

  localparam int DC   = 4;
  localparam int NB   = 4;
  localparam int SWN  = 16;
  localparam int MAXK = 8192;
`ifdef SW_DEBOUNCE_EN
  localparam int SWLAT = 2 + DC;
`else
  localparam int SWLAT = 2;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NB-1:0]   btn_raw = '0;
  logic [SWN-1:0]  sw_raw = '0;
  logic            event_ack = 1'b0;
  logic [NB-1:0]   btn_level;
  logic [SWN-1:0]  sw_value;
  logic [NB-1:0]   btn_event;
  logic            event_valid;
  logic [31:0]     rd_data;

  input_capture_port #(
    .NUM_BTN        (NB),
    .SW_W           (SWN),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3)
  ) dut (
    .clk_100mhz (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .event_ack  (event_ack),
    .btn_level  (btn_level),
    .sw_value   (sw_value),
    .btn_event  (btn_event),
    .event_valid(event_valid),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: raw samples per clock edge since reset release.
  logic [NB-1:0]  bh [MAXK];
  logic [SWN-1:0] sh [MAXK];
  int             k;
  logic [NB-1:0]  m_lvl;
  logic [NB-1:0]  m_evt;
  logic [SWN-1:0] m_sw;

  function automatic logic [NB-1:0] hb(input int i);
    if (i < 0) return '0;
    return bh[i];
  endfunction

  function automatic logic [SWN-1:0] hs(input int i);
    if (i < 0) return '0;
    return sh[i];
  endfunction

  task automatic model_reset();
    k     = 0;
    m_lvl = '0;
    m_evt = '0;
    m_sw  = '0;
  endtask

  // A level is accepted once the last DC synchronized samples
  // (raw delayed by two edges) all hold the opposite value.
  task automatic model_edge(input logic [NB-1:0] b,
                            input logic [SWN-1:0] s,
                            input logic a);
    logic [NB-1:0]  rise;
    logic [NB-1:0]  tb_v;
    logic [SWN-1:0] ts_v;
    logic           want;
    logic           all;
    rise  = '0;
    bh[k] = b;
    sh[k] = s;
    for (int i = 0; i < NB; i++) begin
      want = ~m_lvl[i];
      all  = 1'b1;
      for (int j = 0; j < DC; j++) begin
        tb_v = hb(k - 2 - j);
        if (tb_v[i] != want) all = 1'b0;
      end
      if (all) begin
        m_lvl[i] = want;
        rise[i]  = want;
      end
    end
    m_evt = a ? rise : (m_evt | rise);
`ifdef SW_DEBOUNCE_EN
    for (int i = 0; i < SWN; i++) begin
      want = ~m_sw[i];
      all  = 1'b1;
      for (int j = 0; j < DC; j++) begin
        ts_v = hs(k - 2 - j);
        if (ts_v[i] != want) all = 1'b0;
      end
      if (all) m_sw[i] = want;
    end
`else
    ts_v = hs(k - 1);
    m_sw = ts_v;
`endif
    if (k < MAXK - 1) k++;
  endtask

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [NB-1:0] b,
                      input logic [SWN-1:0] s,
                      input logic a);
    @(negedge clk);
    btn_raw   = b;
    sw_raw    = s;
    event_ack = a;
    @(posedge clk);
    model_edge(b, s, a);
    #1;
    check("model_rd", 64'(rd_data),
          64'({8'h00, m_evt, m_lvl, m_sw}));
    check("model_out",
          64'({btn_level, btn_event, event_valid, sw_value}),
          64'({m_lvl, m_evt, |m_evt, m_sw}));
  endtask

  typedef struct {
    logic [NB-1:0] btn;
    logic          ack;
    int            n;
    logic [NB-1:0] lvl;
    logic [NB-1:0] evt;
    logic          vld;
    logic [31:0]   rd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [NB-1:0]  rb;
    logic [SWN-1:0] rs;
    logic           seen6;

    tbl[0]  = '{4'b0001, 1'b0, 5, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000};
    tbl[1]  = '{4'b0001, 1'b0, 1, 4'b0001, 4'b0001, 1'b1, 32'h0011_0000};
    tbl[2]  = '{4'b0011, 1'b0, 3, 4'b0001, 4'b0001, 1'b1, 32'h0011_0000};
    tbl[3]  = '{4'b0001, 1'b0, 6, 4'b0001, 4'b0001, 1'b1, 32'h0011_0000};
    tbl[4]  = '{4'b0101, 1'b0, 5, 4'b0001, 4'b0001, 1'b1, 32'h0011_0000};
    tbl[5]  = '{4'b0101, 1'b1, 1, 4'b0101, 4'b0100, 1'b1, 32'h0045_0000};
    tbl[6]  = '{4'b0101, 1'b0, 1, 4'b0101, 4'b0100, 1'b1, 32'h0045_0000};
    tbl[7]  = '{4'b1101, 1'b0, 6, 4'b1101, 4'b1100, 1'b1, 32'h00CD_0000};
    tbl[8]  = '{4'b0101, 1'b0, 6, 4'b0101, 4'b1100, 1'b1, 32'h00C5_0000};
    tbl[9]  = '{4'b1101, 1'b0, 6, 4'b1101, 4'b1100, 1'b1, 32'h00CD_0000};
    tbl[10] = '{4'b1101, 1'b1, 1, 4'b1101, 4'b0000, 1'b0, 32'h000D_0000};
    tbl[11] = '{4'b1101, 1'b1, 3, 4'b1101, 4'b0000, 1'b0, 32'h000D_0000};
    tbl[12] = '{4'b0000, 1'b0, 6, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("reset_state",
          64'({rd_data, btn_level, btn_event, event_valid}),
          64'(0));

    for (int r = 0; r < 13; r++) begin
      for (int c = 0; c < tbl[r].n; c++) step(tbl[r].btn, '0, tbl[r].ack);
      check($sformatf("vec%0d_level", r), 64'(btn_level), 64'(tbl[r].lvl));
      check($sformatf("vec%0d_event", r), 64'(btn_event), 64'(tbl[r].evt));
      check($sformatf("vec%0d_valid", r), 64'(event_valid), 64'(tbl[r].vld));
      check($sformatf("vec%0d_rd", r), 64'(rd_data), 64'(tbl[r].rd));
    end

    // Asynchronous reset in the middle of activity.
    repeat (3) step(4'hF, 16'hA5A5, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset",
          64'({rd_data, btn_level, btn_event, event_valid, sw_value}),
          64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int t = 1; t <= 8; t++) begin
      step(4'hF, 16'hA5A5, 1'b0);
      check($sformatf("rst_sw_t%0d", t), 64'(sw_value),
            64'((t >= SWLAT) ? 16'hA5A5 : 16'h0000));
      check($sformatf("rst_evt_t%0d", t), 64'(btn_event),
            64'((t >= 2 + DC) ? 4'hF : 4'h0));
    end

    // Switch latency and a short glitch.
    repeat (8) step(4'hF, 16'h0000, 1'b1);
    for (int t = 1; t <= 8; t++) begin
      step(4'hF, 16'h0020, 1'b0);
      check($sformatf("sw5_t%0d", t), 64'(sw_value[5]),
            64'(t >= SWLAT));
    end
    seen6 = 1'b0;
    repeat (2) begin
      step(4'hF, 16'h0060, 1'b0);
      seen6 = seen6 | sw_value[6];
    end
    repeat (8) begin
      step(4'hF, 16'h0020, 1'b0);
      seen6 = seen6 | sw_value[6];
    end
`ifdef SW_DEBOUNCE_EN
    check("sw6_glitch", 64'(seen6), 64'(0));
`else
    check("sw6_glitch", 64'(seen6), 64'(1));
`endif
    check("sw6_final", 64'(sw_value[6]), 64'(0));

    // Random toggling against the reference model.
    rb = 4'hF;
    rs = 16'h0020;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(4) == 0) rb[i] = ~rb[i];
      rs = rs ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      step(rb, rs, ($urandom_range(7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
